// File: rtl/p_avg_pool_pkg.sv
// Shared data-format types for the perceptron datapath blocks used by the
// windowed mean unit and its power-of-two divider.
package p_avg_pool_pkg;

    typedef enum logic [0:0] {
        INT = 1'b0,
        FXP = 1'b1
    } dtype_t;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    typedef struct packed {
        dtype_t     dtype;
        logic       sign;
        logic [7:0] prec;
        logic [7:0] frac;
    } dconf_t;

    localparam dconf_t DCONF_INT8 = '{dtype: INT, sign: Enable, prec: 8'd8, frac: 8'd0};

    // Two formats are interchangeable when every field agrees.
    function automatic logic conf_match(input dconf_t a, input dconf_t b);
        return (a.dtype == b.dtype) && (a.sign == b.sign) &&
               (a.prec == b.prec) && (a.frac == b.frac);
    endfunction

endpackage

// File: rtl/p_avg_pool_div_pow2.sv
// p_div_pow2: combinational divide by 2^SHIFT with selectable rounding.
// Returns the rounded quotient and the raw low SHIFT bits of the dividend.
module p_div_pow2
    import p_avg_pool_pkg::*;
#(
    parameter int     SHIFT  = 2,
    parameter int     ROUND  = 2,
    parameter dconf_t I_CONF = DCONF_INT8,
    parameter dconf_t O_CONF = DCONF_INT8
) (
    input  logic [I_CONF.prec-1:0] in,
    output logic [O_CONF.prec-1:0] out,
    output logic [SHIFT-1:0]       rem
);

    localparam int IW = int'(I_CONF.prec);
    localparam int OW = int'(O_CONF.prec);

    if (SHIFT < 1) begin : g_shift_err
        $error("p_div_pow2: SHIFT must be at least 1");
    end
    if (OW > IW) begin : g_width_err
        $error("p_div_pow2: output precision exceeds input precision");
    end
    if ((I_CONF.dtype != O_CONF.dtype) || (I_CONF.sign != O_CONF.sign) ||
        (I_CONF.frac != O_CONF.frac)) begin : g_conf_err
        $error("p_div_pow2: input and output formats differ");
    end

    logic [IW-1:0] quot;
    logic          round_up;

    // NOTE: every signal written here gets a value before any branch so no latch is inferred.
    always_comb begin
        quot     = '0;
        round_up = 1'b0;
        rem      = in[SHIFT-1:0];

        // Arithmetic shift floors toward minus infinity, so rem is always the non-negative remainder.
        if (I_CONF.sign) begin
            quot = $signed(in) >>> SHIFT;
        end else begin
            quot = in >> SHIFT;
        end

        case (ROUND)
            1:       round_up = rem[SHIFT-1];
            2:       round_up = |rem;
            default: round_up = 1'b0;
        endcase

        out = quot[OW-1:0] + OW'(round_up);
    end

endmodule

// File: rtl/p_avg_pool.sv
// p_avg_pool: accumulates 2^SHIFT samples and presents their rounded mean
// plus the division remainder on a valid/ready output.
module p_avg_pool
    import p_avg_pool_pkg::*;
#(
    parameter int     SHIFT  = 2,
    parameter int     ROUND  = 2,
    parameter dconf_t I_CONF = DCONF_INT8,
    parameter dconf_t O_CONF = DCONF_INT8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [I_CONF.prec-1:0] in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [O_CONF.prec-1:0] out,
    output logic [SHIFT-1:0]       rem
);

    localparam int I_PREC = int'(I_CONF.prec);
    localparam int O_PREC = int'(O_CONF.prec);
    localparam int N      = 1 << SHIFT;
    localparam int ACC_W  = I_PREC + SHIFT;

    localparam dconf_t ACC_CONF = '{
        dtype: I_CONF.dtype,
        sign:  I_CONF.sign,
        prec:  8'(ACC_W),
        frac:  I_CONF.frac
    };

    if (!conf_match(I_CONF, O_CONF)) begin : g_conf_err
        $error("p_avg_pool: O_CONF must equal I_CONF");
    end

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   sum;
    logic [SHIFT-1:0]   cnt;
    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W-1:0]   sum_next;
    logic [O_PREC-1:0]  div_out;
    logic [SHIFT-1:0]   div_rem;
    logic               accept;
    logic               last;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == SHIFT'(N - 1));

    assign in_ext   = I_CONF.sign ? {{SHIFT{in[I_PREC-1]}}, in} : {{SHIFT{1'b0}}, in};
    assign sum_next = sum + in_ext;

    // The divider sees the sum including the sample being accepted, so the
    // mean is ready to register on the same edge as the final accept.
    p_div_pow2 #(
        .SHIFT  (SHIFT),
        .ROUND  (ROUND),
        .I_CONF (ACC_CONF),
        .O_CONF (O_CONF)
    ) u_div (
        .in  (sum_next),
        .out (div_out),
        .rem (div_rem)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (accept && last) state_next = OUT;
            OUT:     if (out_ready)      state_next = ACC;
            default: state_next = ACC;
        endcase
        if (clear) begin
            state_next = ACC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
            cnt <= '0;
            out <= '0;
            rem <= '0;
        end else if (clear) begin
            sum <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                out <= div_out;
                rem <= div_rem;
                sum <= '0;
                cnt <= '0;
            end else begin
                sum <= sum_next;
                cnt <= cnt + SHIFT'(1);
            end
        end
    end

endmodule

// File: tb/tb_p_avg_pool.sv
// Bench for p_avg_pool: three instances (ROUND 0/1/2) share one stimulus
// stream and are compared against an arithmetic model of the windowed mean.
module tb_p_avg_pool;

    localparam int SHIFT = 2;
    localparam int N     = 1 << SHIFT;
    localparam int NR    = 3;

    logic             clk;
    logic             reset;
    logic             clear;
    logic             in_valid;
    logic [7:0]       in;
    logic             out_ready;
    logic             in_ready_a  [NR];
    logic             out_valid_a [NR];
    logic [7:0]       out_a       [NR];
    logic [SHIFT-1:0] rem_a       [NR];

    for (genvar g = 0; g < NR; g++) begin : g_dut
        p_avg_pool #(
            .SHIFT (SHIFT),
            .ROUND (g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .in_valid  (in_valid),
            .in_ready  (in_ready_a[g]),
            .in        (in),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready),
            .out       (out_a[g]),
            .rem       (rem_a[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted samples and the pending mean per rounding mode.
    int samples[$];
    bit pending;
    int exp_out [NR];
    int exp_rem;

    function automatic int floor_div(input int a);
        if (a >= 0) return a / N;
        return -((-a + N - 1) / N);
    endfunction

    function automatic void finish_window();
        int s;
        int q;
        int r;
        s = 0;
        foreach (samples[i]) s += samples[i];
        q = floor_div(s);
        r = s - q * N;
        exp_out[0] = q;
        exp_out[1] = q + ((r >= N / 2) ? 1 : 0);
        exp_out[2] = q + ((r != 0) ? 1 : 0);
        exp_rem    = r;
        samples.delete();
        pending = 1'b1;
    endfunction

    function automatic void model_reset();
        samples.delete();
        pending = 1'b0;
    endfunction

    task automatic compare_outputs();
        for (int m = 0; m < NR; m++) begin
            check($sformatf("in_ready[%0d]", m), int'(in_ready_a[m]), pending ? 0 : 1);
            check($sformatf("out_valid[%0d]", m), int'(out_valid_a[m]), pending ? 1 : 0);
            if (pending) begin
                check($sformatf("out[%0d]", m), int'($signed(out_a[m])), exp_out[m]);
                check($sformatf("rem[%0d]", m), int'(rem_a[m]), exp_rem);
            end
        end
    endtask

    // One clock: drive inputs while clk is low, advance the model on the edge, compare on the falling edge.
    task automatic cycle(input bit v, input int d, input bit ordy, input bit clr);
        in_valid  = v;
        in        = d[7:0];
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else if (!pending) begin
            if (v) begin
                samples.push_back(d);
                if (samples.size() == N) finish_window();
            end
        end else if (ordy) begin
            pending = 1'b0;
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic window(input int a, input int b, input int c, input int d);
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0);
        cycle(1'b1, c, 1'b0, 1'b0);
        cycle(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic handshake();
        cycle(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        for (int m = 0; m < NR; m++) begin
            check($sformatf("%s out_valid[%0d]", tag, m), int'(out_valid_a[m]), 0);
            check($sformatf("%s out[%0d]", tag, m), int'(out_a[m]), 0);
            check($sformatf("%s rem[%0d]", tag, m), int'(rem_a[m]), 0);
            check($sformatf("%s in_ready[%0d]", tag, m), int'(in_ready_a[m]), 1);
        end
    endtask

    // Reset asserted between edges must act without waiting for a clock.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1 check_reset_values(tag);
        model_reset();
        @(negedge clk);
        check_reset_values({tag, " held"});
        #1 reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in        = '0;
        out_ready = 1'b0;
        @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;

        // Positive window, then negative window (floor vs. ceiling differ).
        window(1, 2, 3, 4);
        handshake();
        window(-1, -2, -3, -4);
        handshake();

        // Extremes of the signed range.
        window(127, 127, 127, 127);
        handshake();
        window(-128, -128, -128, -128);
        handshake();

        // Backpressure: in_valid pulses are ignored while the result waits.
        window(10, 11, 12, 14);
        for (int i = 0; i < 10; i++) cycle(i[0], 99, 1'b0, 1'b0);
        handshake();
        window(5, 5, 5, 5);
        handshake();

        // Idle gaps between samples keep the partial window.
        cycle(1'b1, 3, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, -6, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b1, 2, 1'b0, 1'b0);
        cycle(1'b1, 0, 1'b0, 1'b0);
        handshake();

        // Clear drops the partial window and the concurrent sample.
        cycle(1'b1, 7, 1'b0, 1'b0);
        cycle(1'b1, 9, 1'b0, 1'b0);
        cycle(1'b1, 100, 1'b0, 1'b1);
        window(4, 4, 4, 4);
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // Asynchronous reset mid-window and while holding a result.
        cycle(1'b1, 50, 1'b0, 1'b0);
        cycle(1'b1, 60, 1'b0, 1'b0);
        async_reset("rst_acc");
        window(8, 8, 8, 8);
        async_reset("rst_out");
        window(8, 8, 8, 8);
        handshake();

        // Randomized traffic with occasional clears and extreme samples.
        for (int i = 0; i < 2000; i++) begin
            int d;
            if ($urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) == 1) ? 127 : -128;
            else d = int'($urandom_range(0, 255)) - 128;
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/p_avg_pool.md
# p_avg_pool

Windowed mean unit for the perceptron datapath. Accepts a stream of 2^SHIFT samples over a valid/ready handshake and accumulates them into a full-width sum. It divides the sum by the window size through one `p_div_pow2` instance and presents the registered mean, with the division remainder, on a valid/ready output. Used for average pooling and for batch-mean normalization ahead of the activation stage.

## Interface
- `SHIFT`, default 2: log2 of the window length; samples per window N = 1<<SHIFT; SHIFT >= 1.
- `ROUND`, default 2: passed to `p_div_pow2`.
  - 0: discard lower bits.
  - 1: round up if rem >= N/2.
  - 2: round up if rem != 0.
- `I_CONF`, default `dconf_t'{INT, Enable, 8, 0}`: sample format.
- `O_CONF`, default `dconf_t'{INT, Enable, 8, 0}`: result format. Must match I_CONF in dtype, sign, prec and frac; any mismatch is an elaboration `$error`.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `clear` input 1: synchronous window abort.
- `in_valid` input 1: sample valid.
- `in_ready` output 1: block accepts a sample this cycle.
- `in` input I_PREC: sample.
- `out_valid` output 1: mean valid.
- `out_ready` input 1: consumer accepts the mean.
- `out` output O_PREC: rounded mean.
- `rem` output SHIFT: low SHIFT bits of the window sum, i.e. the remainder before rounding.

## Operation
- States: ACC (accumulating) and OUT (holding the result).
- A sample is accepted when in_valid && in_ready.
- Accumulator `sum` has width I_PREC+SHIFT, so overflow is impossible.
  - Each accepted sample is sign-extended if I_CONF.sign, zero-extended otherwise, then added to `sum`.
- Counter `cnt` has SHIFT bits and counts accepted samples.
- ACC:
  - in_ready = 1.
  - On accept with cnt != N-1: sum += ext(in), cnt += 1.
  - On accept with cnt == N-1:
    - The final sum (sum + ext(in)) drives the `p_div_pow2` input combinationally.
    - Its out and rem are registered into `out` and `rem`.
    - sum <= 0, cnt <= 0, go to OUT.
- OUT:
  - in_ready = 0, out_valid = 1.
  - out and rem hold stable until out_valid && out_ready.
  - On that handshake, go to ACC.
- Divider instance configuration: I_CONF with prec = I_PREC+SHIFT, and O_CONF. The mean of in-range samples is always in range, so no saturation is required.
- clear has priority over every other event:
  - sum <= 0, cnt <= 0, out_valid <= 0, state <= ACC.
  - A sample presented in the same cycle is dropped, and in_ready is still 1 if the state was ACC.
  - A pending result in OUT is discarded.
- reset, at any time, asynchronously forces:
  - state = ACC, sum = 0, cnt = 0.
  - out = 0, rem = 0, out_valid = 0.
  - in_ready = 1 once reset is released.

## Timing
- Reset values: out_valid 0, out 0, rem 0, in_ready 1.
- Latency: if the Nth sample is accepted on edge t, out_valid is 1 after edge t.
- Minimum window period is N+1 cycles: N accepts, plus 1 cycle in OUT with out_ready = 1.
- in_ready is a function of state only, never of in_valid.
- out_valid does not depend on out_ready.
- Backpressure: while out_ready = 0, OUT persists indefinitely and out/rem do not change.
- in_valid may drop between samples. cnt and sum hold across idle cycles.

## Structure
- `dconf_t`, `dtype_t` and the `INT`/`FXP` enumerators come from the shared perceptron package (`perceptron.svh`). No new typedefs are needed.
- Add a local state enum `{ACC, OUT}`.
- Derive localparams N and ACC_W = I_PREC+SHIFT in the module.
- `Enable`/`Disable` come from `stddef.vh`.
- Exactly one sub-module: `p_div_pow2`, instantiated combinationally on the next-sum value. Registering happens in this block.

## Test plan
All cases use SHIFT=2, ROUND=2, INT signed 8-bit unless noted.
1. Samples 1, 2, 3, 4 back-to-back → out_valid one cycle after the 4th accept; out = 3, rem = 2.
2. Samples -1, -2, -3, -4 → sum -10; out = -2, rem = 2. Repeat with ROUND=0 → out = -3, rem = 2.
3. Four samples of 127, then four of -128 → out = 127, rem = 0, then out = -128, rem = 0.
4. Hold out_ready = 0 for 10 cycles after the result → out/rem stable, in_ready = 0, and in_valid pulses are ignored. Raise out_ready → a handshake in 1 cycle, then the next window of 5, 5, 5, 5 gives out = 5.
5. Accept 2 samples (7, 9), assert clear together with a third sample of 100, then feed 4, 4, 4, 4 → out = 4. Also assert clear while in OUT → out_valid drops next cycle.
6. Assert reset asynchronously mid-window and again in OUT → all outputs return to reset values immediately. Window 8, 8, 8, 8 after release → out = 8.
